// File: rtl/if_id_queue.sv
// Decoupling IF->ID instruction queue: DEPTH entries of {instr, pc, pc+4}.
// Optional performance counters enabled by defining IFQ_PERF_EN.

module if_id_queue_slot #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage only; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module if_id_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ValidF,
  input  logic [31:0]            InstrF,
  input  logic [31:0]            PCF,
  input  logic [31:0]            PCPlus4F,
  input  logic                   StallD,
  input  logic                   FlushD,
  output logic                   FullF,
  output logic                   ValidD,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCD,
  output logic [31:0]            PCPlus4D,
  output logic [$clog2(DEPTH):0] CountQ
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]            FullCyclesQ,
  output logic [31:0]            FlushedInstrsQ
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifq_entry_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          push, pop;
  ifq_entry_t    wr_ent, head;
  ifq_entry_t    slot_q [DEPTH];
  logic [DEPTH-1:0] slot_we;

  // Flags decode registered count only, so no input reaches an output.
  assign FullF  = (count_q == CW'(DEPTH));
  assign ValidD = (count_q != '0);
  assign CountQ = count_q;

  assign push = ValidF && !FullF && !FlushD;
  assign pop  = ValidD && !StallD && !FlushD;

  assign wr_ent = '{instr: InstrF, pc: PCF, pc4: PCPlus4F};

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign slot_we[g] = push && (wr_ptr == AW'(g));
      if_id_queue_slot #(.W($bits(ifq_entry_t))) u_slot (
        .clk (clk),
        .we  (slot_we[g]),
        .d   (wr_ent),
        .q   (slot_q[g])
      );
    end
  endgenerate

  always_comb begin
    head = '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
    if (ValidD) head = slot_q[rd_ptr];
  end

  assign InstrD   = head.instr;
  assign PCD      = head.pc;
  assign PCPlus4D = head.pc4;

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IFQ_PERF_EN
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, FlushedInstrsQ} + 33'(count_q) + 33'(ValidF);

  always_ff @(posedge clk) begin
    if (rst) begin
      FullCyclesQ    <= '0;
      FlushedInstrsQ <= '0;
    end else begin
      if (FullF && ValidF && (FullCyclesQ != 32'hFFFF_FFFF))
        FullCyclesQ <= FullCyclesQ + 32'd1;
      // Wrong-path work lost on a redirect: queued entries plus the incoming one.
      if (FlushD)
        FlushedInstrsQ <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, streaming, fill/stall, wrap, flush, mid-stream reset.
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        ValidF, StallD, FlushD;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        FullF, ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic [2:0]  CountQ;
`ifdef IFQ_PERF_EN
  logic [31:0] FullCyclesQ, FlushedInstrsQ;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .StallD(StallD), .FlushD(FlushD), .FullF(FullF),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .CountQ(CountQ)
`ifdef IFQ_PERF_EN
    , .FullCyclesQ(FullCyclesQ), .FlushedInstrsQ(FlushedInstrsQ)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    ValidF   = v;
    PCF      = pc;
    InstrF   = ins(pc);
    PCPlus4F = pc + 32'd4;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input int cnt);
    chk({tag, ".valid"}, 32'(ValidD), 32'd1);
    chk({tag, ".pc"},    PCD, pc);
    chk({tag, ".instr"}, InstrD, ins(pc));
    chk({tag, ".pc4"},   PCPlus4D, pc + 32'd4);
    chk({tag, ".count"}, 32'(CountQ), 32'(cnt));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 32'(ValidD), 32'd0);
    chk({tag, ".instr"}, InstrD, 32'h0000_0013);
    chk({tag, ".pc"},    PCD, 32'd0);
    chk({tag, ".pc4"},   PCPlus4D, 32'd0);
    chk({tag, ".count"}, 32'(CountQ), 32'd0);
    chk({tag, ".full"},  32'(FullF), 32'd0);
  endtask

  initial begin
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk_empty("reset");
    rst = 1'b0;
    tick();
    chk_empty("idle");

    // Streaming: each push surfaces one cycle later, count never exceeds 1
    drive(1'b1, 32'h0); tick(); chk_head("stream0", 32'h0, 1);
    drive(1'b1, 32'h4); tick(); chk_head("stream4", 32'h4, 1);
    drive(1'b1, 32'h8); tick(); chk_head("stream8", 32'h8, 1);
    drive(1'b0, 32'h0); tick(); chk_empty("stream_end");

    // Fill under stall
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(4 * i)); tick();
      chk_head("fill", 32'h10, i + 1);
      chk("fill.full", 32'(FullF), (i == 3) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 32'h20); tick();
    chk_head("full_hold", 32'h10, 4);
    chk("full_hold.full", 32'(FullF), 32'd1);
    StallD = 1'b0; tick();            // pop only; push blocked by registered FullF
    chk_head("drain10", 32'h14, 3);
    chk("drain10.full", 32'(FullF), 32'd0);
    tick();                           // pop 0x14, 0x20 accepted
    chk_head("drain14", 32'h18, 3);
    drive(1'b0, 32'h0);
    tick(); chk_head("drain18", 32'h1C, 2);
    tick(); chk_head("drain1c", 32'h20, 1);
    tick(); chk_empty("drained");

    // Simultaneous push/pop at count 2, pointers wrap past index 3
    StallD = 1'b1;
    drive(1'b1, 32'h40); tick();
    drive(1'b1, 32'h44); tick();
    chk_head("wrap_pre", 32'h40, 2);
    StallD = 1'b0;
    for (int k = 2; k < 8; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k)); tick();
      chk_head("wrap", 32'h40 + 32'(4 * (k - 1)), 2);
    end
    drive(1'b0, 32'h0);
    tick(); chk_head("wrap_d0", 32'h5C, 1);
    tick(); chk_empty("wrap_done");

    // Flush with 3 queued plus incoming, while stalled
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i)); tick();
    end
    chk_head("preflush", 32'h80, 3);
    drive(1'b1, 32'h100); FlushD = 1'b1; tick();
    chk_empty("flush");
    FlushD = 1'b0; drive(1'b0, 32'h0); tick();
    chk_empty("post_flush");
    StallD = 1'b0;
    drive(1'b1, 32'h200); tick();
    chk_head("refill", 32'h200, 1);
    drive(1'b0, 32'h0); tick();
    chk_empty("refill_done");
`ifdef IFQ_PERF_EN
    chk("perf.full_cycles", FullCyclesQ, 32'd2);
    chk("perf.flushed", FlushedInstrsQ, 32'd4);
`endif

    // Reset mid-stream with count 3 and a valid incoming instruction
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i)); tick();
    end
    chk_head("prereset", 32'h300, 3);
    rst = 1'b1; drive(1'b1, 32'h30C); tick();
    chk_empty("midreset");
`ifdef IFQ_PERF_EN
    chk("midreset.full_cycles", FullCyclesQ, 32'd0);
    chk("midreset.flushed", FlushedInstrsQ, 32'd0);
`endif
    rst = 1'b0; StallD = 1'b0;
    drive(1'b1, 32'h400); tick();
    chk_head("after_reset", 32'h400, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
